// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage buffers: state encoding,
// default field widths, and a saturating increment helper.
package pipe_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned MEM_CTRL_W = 4;
    localparam int unsigned WB_CTRL_W  = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_t;

    // Increment that sticks at maxValue instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] maxValue);
        return (value >= maxValue) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at its all-ones value.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= CNT_W'(sat_inc(32'(count), 32'(CNT_MAX)));
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register: main + skid entry so in_ready comes from state
// only, with flush either bubbling (ctrl cleared) or dropping held entries.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W            = 101,
    parameter int unsigned CTRL_W            = 6,
    parameter bit          FLUSH_KEEP_BUBBLE = 1'b1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    bufState_t         state, stateNxt;
    logic              mainValid, mainValidNxt;
    logic [DATA_W-1:0] mainData, mainDataNxt;
    logic [CTRL_W-1:0] mainCtrl, mainCtrlNxt;
    logic              skidValid, skidValidNxt;
    logic [DATA_W-1:0] skidData, skidDataNxt;
    logic [CTRL_W-1:0] skidCtrl, skidCtrlNxt;

    logic inFire;
    logic outFire;

    assign in_ready  = (state != FULL) & ~rst;
    assign inFire    = in_valid & in_ready;
    assign outFire   = mainValid & out_ready;
    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign out_ctrl  = mainCtrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            mainValid <= 1'b0;
            mainData  <= '0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidData  <= '0;
            skidCtrl  <= '0;
        end else begin
            state     <= stateNxt;
            mainValid <= mainValidNxt;
            mainData  <= mainDataNxt;
            mainCtrl  <= mainCtrlNxt;
            skidValid <= skidValidNxt;
            skidData  <= skidDataNxt;
            skidCtrl  <= skidCtrlNxt;
        end
    end

    always_comb begin
        stateNxt     = state;
        mainValidNxt = mainValid;
        mainDataNxt  = mainData;
        mainCtrlNxt  = mainCtrl;
        skidValidNxt = skidValid;
        skidDataNxt  = skidData;
        skidCtrlNxt  = skidCtrl;

        if (flush && !FLUSH_KEEP_BUBBLE) begin
            // Drop mode: everything held (and anything accepted now) is discarded.
            stateNxt     = EMPTY;
            mainValidNxt = 1'b0;
            mainCtrlNxt  = '0;
            skidValidNxt = 1'b0;
            skidCtrlNxt  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (inFire) begin
                        stateNxt     = ONE;
                        mainValidNxt = 1'b1;
                        mainDataNxt  = in_data;
                        mainCtrlNxt  = in_ctrl;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainDataNxt = in_data;
                        mainCtrlNxt = in_ctrl;
                    end else if (inFire) begin
                        stateNxt     = FULL;
                        skidValidNxt = 1'b1;
                        skidDataNxt  = in_data;
                        skidCtrlNxt  = in_ctrl;
                    end else if (outFire) begin
                        stateNxt     = EMPTY;
                        mainValidNxt = 1'b0;
                    end
                end
                FULL: begin
                    if (outFire) begin
                        stateNxt     = ONE;
                        mainValidNxt = skidValid;
                        mainDataNxt  = skidData;
                        mainCtrlNxt  = skidCtrl;
                        skidValidNxt = 1'b0;
                    end
                end
                default: begin
                    stateNxt     = EMPTY;
                    mainValidNxt = 1'b0;
                    skidValidNxt = 1'b0;
                end
            endcase

            // Bubble mode: whatever ends up held after this cycle becomes a no-op.
            if (flush) begin
                mainCtrlNxt = '0;
                skidCtrlNxt = '0;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mainValid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: bubble-flush, drop-flush and 4-bit counter
// instances share one stimulus stream; each phase checks the relevant instance.
module tb_pipe_stage_buf;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 6;

    logic          clk;
    logic          rst;
    logic          inValid;
    logic [DW-1:0] inData;
    logic [CW-1:0] inCtrl;
    logic          flush;
    logic          outReady;

    logic [2:0]    inReady;
    logic [2:0]    outValid;
    logic [DW-1:0] outData [3];
    logic [CW-1:0] outCtrl [3];
    logic [15:0]   stall0, flush0, stall1, flush1;
    logic [3:0]    stall2, flush2;

    int nChk  = 0;
    int nFail = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_KEEP_BUBBLE(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]),
        .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
        .out_valid(outValid[0]), .out_ready(outReady), .out_data(outData[0]),
        .out_ctrl(outCtrl[0]), .stall_cnt(stall0), .flush_cnt(flush0)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_KEEP_BUBBLE(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]),
        .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
        .out_valid(outValid[1]), .out_ready(outReady), .out_data(outData[1]),
        .out_ctrl(outCtrl[1]), .stall_cnt(stall1), .flush_cnt(flush1)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_KEEP_BUBBLE(1'b1), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[2]),
        .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
        .out_valid(outValid[2]), .out_ready(outReady), .out_data(outData[2]),
        .out_ctrl(outCtrl[2]), .stall_cnt(stall2), .flush_cnt(flush2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          r;
        logic          v;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          f;
        logic          o;
        logic          eIr;
        logic          eOv;
        logic [DW-1:0] eD;
        logic [CW-1:0] eC;
        logic [15:0]   eStall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                input logic f, o, eIr, eOv, input logic [DW-1:0] eD,
                                input logic [CW-1:0] eC, input logic [15:0] eStall);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c; t.f = f; t.o = o;
        t.eIr = eIr; t.eOv = eOv; t.eD = eD; t.eC = eC; t.eStall = eStall;
        return t;
    endfunction

    // Drive one cycle's inputs at the falling edge; outputs then reflect the prior rising edge.
    task automatic apply(input logic r, v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic f, o);
        @(negedge clk);
        rst = r; inValid = v; inData = d; inCtrl = c; flush = f; outReady = o;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; inData = '0; inCtrl = '0; flush = 1'b0; outReady = 1'b1;
        repeat (2) @(posedge clk);

        // Reset row, 1..8 streaming, then A,B under 3 cycles of backpressure.
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        for (int k = 2; k <= 8; k++)
            vecs.push_back(mk(0, 1, DW'(k), CW'(k), 0, 1, 1, 1, DW'(k - 1), CW'(k - 1), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 16'h8, 6'h8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h8, 6'h8, 0));
        vecs.push_back(mk(0, 1, 16'hA, 6'hA, 0, 0, 1, 0, 16'h8, 6'h8, 0));
        vecs.push_back(mk(0, 1, 16'hB, 6'hB, 0, 0, 1, 1, 16'hA, 6'hA, 0));
        vecs.push_back(mk(0, 1, 16'hC, 6'hC, 0, 0, 0, 1, 16'hA, 6'hA, 1));
        vecs.push_back(mk(0, 1, 16'hC, 6'hC, 0, 0, 0, 1, 16'hA, 6'hA, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 16'hA, 6'hA, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 16'hB, 6'hB, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'hB, 6'hB, 3));

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].f, vecs[i].o);
            chk($sformatf("row%0d in_ready", i), 32'(inReady[0]), 32'(vecs[i].eIr));
            chk($sformatf("row%0d out_valid", i), 32'(outValid[0]), 32'(vecs[i].eOv));
            chk($sformatf("row%0d out_data", i), 32'(outData[0]), 32'(vecs[i].eD));
            chk($sformatf("row%0d out_ctrl", i), 32'(outCtrl[0]), 32'(vecs[i].eC));
            chk($sformatf("row%0d stall_cnt", i), 32'(stall0), 32'(vecs[i].eStall));
        end

        // Fill to FULL then flush: bubble keeps both entries, drop empties.
        apply(0, 1, 16'h11, 6'h3F, 0, 0);
        apply(0, 1, 16'h22, 6'h15, 0, 0);
        apply(0, 1, 16'h33, 6'h01, 1, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("bubble out_valid", 32'(outValid[0]), 32'd1);
        chk("bubble out_data", 32'(outData[0]), 32'h11);
        chk("bubble out_ctrl", 32'(outCtrl[0]), 32'd0);
        chk("bubble in_ready", 32'(inReady[0]), 32'd0);
        chk("bubble flush_cnt", 32'(flush0), 32'd1);
        chk("drop full out_valid", 32'(outValid[1]), 32'd0);
        chk("drop full in_ready", 32'(inReady[1]), 32'd1);
        chk("drop flush_cnt", 32'(flush1), 32'd1);
        apply(0, 0, 0, 0, 0, 1);
        chk("bubble drain1 data", 32'(outData[0]), 32'h11);
        chk("bubble drain1 ctrl", 32'(outCtrl[0]), 32'd0);
        apply(0, 0, 0, 0, 0, 1);
        chk("bubble drain2 valid", 32'(outValid[0]), 32'd1);
        chk("bubble drain2 data", 32'(outData[0]), 32'h22);
        chk("bubble drain2 ctrl", 32'(outCtrl[0]), 32'd0);
        apply(0, 0, 0, 0, 0, 1);
        chk("bubble drained", 32'(outValid[0]), 32'd0);

        // Flush coinciding with an accepted entry C.
        apply(0, 1, 16'h44, 6'h07, 0, 0);
        apply(0, 1, 16'h55, 6'h2A, 1, 0);
        chk("drop accept ready", 32'(inReady[1]), 32'd1);
        apply(0, 0, 0, 0, 0, 1);
        chk("drop C out_valid", 32'(outValid[1]), 32'd0);
        chk("drop C in_ready", 32'(inReady[1]), 32'd1);
        chk("bubble C main data", 32'(outData[0]), 32'h44);
        chk("bubble C main ctrl", 32'(outCtrl[0]), 32'd0);
        chk("bubble C in_ready", 32'(inReady[0]), 32'd0);
        apply(0, 0, 0, 0, 0, 1);
        chk("drop C never1", 32'(outValid[1]), 32'd0);
        chk("bubble C skid data", 32'(outData[0]), 32'h55);
        chk("bubble C skid ctrl", 32'(outCtrl[0]), 32'd0);
        apply(0, 0, 0, 0, 0, 1);
        chk("drop C never2", 32'(outValid[1]), 32'd0);

        // Reset while FULL, with a simultaneous flush that reset must override.
        apply(0, 1, 16'h66, 6'h3F, 0, 0);
        apply(0, 1, 16'h77, 6'h3F, 0, 0);
        apply(1, 0, 0, 0, 1, 1);
        chk("rst in_ready", 32'(inReady[0]), 32'd0);
        apply(0, 0, 0, 0, 0, 1);
        chk("rst out_valid", 32'(outValid[0]), 32'd0);
        chk("rst out_data", 32'(outData[0]), 32'd0);
        chk("rst out_ctrl", 32'(outCtrl[0]), 32'd0);
        chk("rst stall_cnt", 32'(stall0), 32'd0);
        chk("rst flush_cnt", 32'(flush0), 32'd0);
        chk("rst in_ready after", 32'(inReady[0]), 32'd1);

        // Long stall: 4-bit counter pins at 15, 16-bit keeps counting.
        apply(0, 1, 16'h99, 6'h01, 0, 0);
        for (int k = 0; k < 20; k++) apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("sat stall_cnt 4b", 32'(stall2), 32'd15);
        chk("sat stall_cnt 16b", 32'(stall0), 32'd20);
        repeat (5) apply(0, 0, 0, 0, 0, 0);
        chk("sat hold 4b", 32'(stall2), 32'd15);
        chk("sat hold 16b", 32'(stall0), 32'd25);
        chk("sat hold data", 32'(outData[2]), 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
